// File: rtl/set_assoc_miss_handler_pkg.sv
// Shared constants, FSM state type and line helpers for the 2-way read-cache refill path.
package set_assoc_miss_handler_pkg;

  localparam int TAG_W     = 5;
  localparam int IDX_W     = 7;
  localparam int OFF_W     = 2;
  localparam int WORD_W    = 32;
  localparam int LINE_W    = 134;
  localparam int VALID_BIT = 133;
  localparam int TAG_MSB   = 132;
  localparam int TAG_LSB   = 128;
  localparam int DATA_MSB  = 127;

  // Byte-address field positions: tag[15:11], index[10:4], word[3:2]
  localparam int WORD_LSB  = 2;
  localparam int IDX_LSB   = 4;
  localparam int TAG_ALSB  = 11;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL,
    RESP
  } state_t;

  // Word 0 lives in the most significant slot of the line data.
  function automatic logic [WORD_W-1:0] word_slice(input logic [DATA_MSB:0] data,
                                                   input logic [OFF_W-1:0]  sel);
    return data[DATA_MSB - WORD_W*int'(sel) -: WORD_W];
  endfunction

endpackage

// File: rtl/set_assoc_lru.sv
// Per-set LRU bit store: value names the way to evict next.
module set_assoc_lru #(
  parameter int SETS  = 128,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_value,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_value
);

  logic [SETS-1:0] lru_bits;

  // Clear all sets on reset, otherwise single write port update
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_bits <= '0;
    end else if (wr_en) begin
      lru_bits[wr_index] <= wr_value;
    end
  end

  assign rd_value = lru_bits[rd_index];

endmodule

// File: rtl/set_assoc_miss_handler.sv
// Refill controller for the 2-way, 4-word-line read cache: fetch, victim fill, word return.
module set_assoc_miss_handler
  import set_assoc_miss_handler_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int SETS   = 128,
  parameter int WORDS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  input  logic              hit_i,
  input  logic              hit_way_i,
  input  logic              valid0_i,
  input  logic              valid1_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              fill_we_o,
  output logic              fill_way_o,
  output logic [IDX_W-1:0]  fill_index_o,
  output logic [LINE_W-1:0] fill_line_o,
  output logic              resp_valid_o,
  output logic [WORD_W-1:0] resp_data_o
);

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  state_t                     state_q, state_d;
  logic [ADDR_W-1:WORD_LSB]   addr_q;
  logic                       victim_q;
  logic [OFF_W-1:0]           beat_q;
  logic [DATA_MSB:0]          data_q;

  logic                       miss_accept;
  logic                       lru_rd_value;
  logic                       lru_we;
  logic [IDX_W-1:0]           lru_windex;
  logic                       lru_wvalue;
  logic [IDX_W-1:0]           req_index;
  logic                       unused_byte_bits;

  assign req_index        = req_addr_i[IDX_LSB +: IDX_W];
  assign unused_byte_bits = ^req_addr_i[WORD_LSB-1:0];

  set_assoc_lru #(
    .SETS  (SETS),
    .IDX_W (IDX_W)
  ) u_lru (
    .clk      (clk_i),
    .rst      (rst_i),
    .rd_index (req_index),
    .rd_value (lru_rd_value),
    .wr_en    (lru_we),
    .wr_index (lru_windex),
    .wr_value (lru_wvalue)
  );

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake/memory/fill/response outputs and LRU write port
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    mem_req_o    = 1'b0;
    mem_addr_o   = '0;
    fill_we_o    = 1'b0;
    fill_way_o   = 1'b0;
    fill_index_o = '0;
    fill_line_o  = '0;
    resp_valid_o = 1'b0;
    resp_data_o  = '0;
    miss_accept  = 1'b0;
    lru_we       = 1'b0;
    lru_windex   = req_index;
    lru_wvalue   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (hit_i) begin
            lru_we     = 1'b1;
            lru_wvalue = ~hit_way_i;
          end else begin
            miss_accept = 1'b1;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_q[ADDR_W-1:IDX_LSB], beat_q, 2'b00};
        if (mem_ack_i && (beat_q == LAST_BEAT)) begin
          state_d = FILL;
        end
      end
      FILL: begin
        fill_we_o                   = 1'b1;
        fill_way_o                  = victim_q;
        fill_index_o                = addr_q[IDX_LSB +: IDX_W];
        fill_line_o[VALID_BIT]      = 1'b1;
        fill_line_o[TAG_MSB:TAG_LSB] = addr_q[TAG_ALSB +: TAG_W];
        fill_line_o[DATA_MSB:0]     = data_q;
        lru_we                      = 1'b1;
        lru_windex                  = addr_q[IDX_LSB +: IDX_W];
        lru_wvalue                  = ~victim_q;
        state_d                     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_data_o  = word_slice(data_q, addr_q[WORD_LSB +: OFF_W]);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss capture (address, victim choice) and beat-by-beat line assembly
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      victim_q <= 1'b0;
      beat_q   <= '0;
      data_q   <= '0;
    end else if (miss_accept) begin
      addr_q   <= req_addr_i[ADDR_W-1:WORD_LSB];
      victim_q <= !valid0_i ? 1'b0 : (!valid1_i ? 1'b1 : lru_rd_value);
      beat_q   <= '0;
    end else if ((state_q == FETCH) && mem_ack_i) begin
      data_q[DATA_MSB - WORD_W*int'(beat_q) -: WORD_W] <= mem_rdata_i;
      beat_q <= beat_q + 2'd1;
    end
  end

endmodule

// File: tb/tb_set_assoc_miss_handler.sv
// Scoreboard bench for the refill controller: expectations queued at request time,
// popped as memory requests, fills and responses appear.
module tb_set_assoc_miss_handler;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic [15:0]  req_addr_i;
  logic         req_ready_o;
  logic         hit_i;
  logic         hit_way_i;
  logic         valid0_i;
  logic         valid1_i;
  logic         mem_req_o;
  logic [15:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [31:0]  mem_rdata_i;
  logic         fill_we_o;
  logic         fill_way_o;
  logic [6:0]   fill_index_o;
  logic [133:0] fill_line_o;
  logic         resp_valid_o;
  logic [31:0]  resp_data_o;

  always #5 clk_i = ~clk_i;

  set_assoc_miss_handler #(
    .ADDR_W (16),
    .SETS   (128),
    .WORDS  (4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_addr_i   (req_addr_i),
    .req_ready_o  (req_ready_o),
    .hit_i        (hit_i),
    .hit_way_i    (hit_way_i),
    .valid0_i     (valid0_i),
    .valid1_i     (valid1_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .fill_we_o    (fill_we_o),
    .fill_way_o   (fill_way_o),
    .fill_index_o (fill_index_o),
    .fill_line_o  (fill_line_o),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o)
  );

  typedef struct {
    logic         way;
    logic [6:0]   idx;
    logic [133:0] line;
  } fill_t;

  int unsigned checks = 0;
  int unsigned passes = 0;

  logic [15:0] exp_addr_q[$];
  fill_t       exp_fill_q[$];
  logic [31:0] exp_resp_q[$];
  logic        lru_m [128];

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a ^ 16'h3C5A};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 128; i++) lru_m[i] = 1'b0;
    exp_addr_q.delete();
    exp_fill_q.delete();
    exp_resp_q.delete();
  endtask

  task automatic push_miss(input logic [15:0] a, input logic v0, input logic v1);
    fill_t       f;
    logic [15:0] base;
    base   = {a[15:4], 4'h0};
    f.idx  = a[10:4];
    f.way  = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_m[f.idx]);
    f.line = {1'b1, a[15:11], mem_word(base), mem_word(base + 16'd4),
              mem_word(base + 16'd8), mem_word(base + 16'd12)};
    for (int b = 0; b < 4; b++) exp_addr_q.push_back(base + 16'(b * 4));
    exp_fill_q.push_back(f);
    exp_resp_q.push_back(mem_word({a[15:2], 2'b00}));
  endtask

  task automatic start_miss(input logic [15:0] a, input logic v0, input logic v1, input logic hold);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    hit_i       = 1'b0;
    valid0_i    = v0;
    valid1_i    = v1;
    checks++;
    if (req_ready_o !== 1'b1) $display("FAIL accept_ready: got %b expected 1", req_ready_o);
    else passes++;
    push_miss(a, v0, v1);
    @(posedge clk_i);
    #1;
    if (!hold) req_valid_i = 1'b0;
  endtask

  // Memory responder plus scoreboard pop/compare, until n_resp responses are seen.
  task automatic service(input int waits, input int n_resp, output int fill_rel, output int resp_rel);
    int    wcnt;
    int    nr;
    fill_t f;
    logic [31:0] r;
    wcnt = 0;
    nr = 0;
    fill_rel = -1;
    resp_rel = -1;
    for (int rel = 1; rel <= 80 && nr < n_resp; rel++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      checks++;
      if (req_ready_o !== 1'b0) $display("FAIL busy_ready: got %b expected 0 (rel %0d)", req_ready_o, rel);
      else passes++;
      if (mem_req_o) begin
        checks++;
        if (exp_addr_q.size() == 0) $display("FAIL mem_addr: got %h expected no request", mem_addr_o);
        else if (mem_addr_o !== exp_addr_q[0])
          $display("FAIL mem_addr: got %h expected %h (rel %0d)", mem_addr_o, exp_addr_q[0], rel);
        else passes++;
        if (wcnt >= waits) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      if (fill_we_o) begin
        checks++;
        if (exp_fill_q.size() == 0) begin
          $display("FAIL fill: got write at index %h expected none", fill_index_o);
        end else begin
          f = exp_fill_q.pop_front();
          if (fill_way_o !== f.way || fill_index_o !== f.idx || fill_line_o !== f.line)
            $display("FAIL fill: got way %b idx %h line %h expected way %b idx %h line %h",
                     fill_way_o, fill_index_o, fill_line_o, f.way, f.idx, f.line);
          else passes++;
          lru_m[f.idx] = ~f.way;
        end
        if (fill_rel < 0) fill_rel = rel;
      end
      if (resp_valid_o) begin
        checks++;
        if (exp_resp_q.size() == 0) begin
          $display("FAIL resp: got %h expected none", resp_data_o);
        end else begin
          r = exp_resp_q.pop_front();
          if (resp_data_o !== r) $display("FAIL resp: got %h expected %h", resp_data_o, r);
          else passes++;
        end
        if (resp_rel < 0) resp_rel = rel;
        nr++;
      end
    end
    mem_ack_i = 1'b0;
    checks++;
    if (nr < n_resp) $display("FAIL refill_timeout: got %0d responses expected %0d", nr, n_resp);
    else passes++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; hit_i = 1'b0; hit_way_i = 1'b0;
    valid0_i = 1'b0; valid1_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    clear_model();
    repeat (3) @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1) $display("FAIL rst_ready: got %b expected 1", req_ready_o); else passes++;
    checks++; if (mem_req_o !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", mem_req_o); else passes++;
    checks++; if (mem_addr_o !== 16'h0) $display("FAIL rst_mem_addr: got %h expected 0", mem_addr_o); else passes++;
    checks++; if (fill_we_o !== 1'b0) $display("FAIL rst_fill_we: got %b expected 0", fill_we_o); else passes++;
    checks++; if (fill_way_o !== 1'b0) $display("FAIL rst_fill_way: got %b expected 0", fill_way_o); else passes++;
    checks++; if (fill_index_o !== 7'h0) $display("FAIL rst_fill_index: got %h expected 0", fill_index_o); else passes++;
    checks++; if (fill_line_o !== 134'h0) $display("FAIL rst_fill_line: got %h expected 0", fill_line_o); else passes++;
    checks++; if (resp_valid_o !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", resp_valid_o); else passes++;
    checks++; if (resp_data_o !== 32'h0) $display("FAIL rst_resp_data: got %h expected 0", resp_data_o); else passes++;
    rst_i = 1'b0;
  endtask

  task automatic test_miss_basic();
    int fr, rr;
    start_miss(16'h0A34, 1'b0, 1'b0, 1'b0);
    service(0, 1, fr, rr);
    checks++; if (fr != 5) $display("FAIL basic_fill_latency: got %0d expected 5", fr); else passes++;
    checks++; if (rr != 6) $display("FAIL basic_resp_latency: got %0d expected 6", rr); else passes++;
  endtask

  task automatic test_victim_select();
    int fr, rr;
    start_miss(16'h0100, 1'b1, 1'b0, 1'b0);
    service(0, 1, fr, rr);
    start_miss(16'h0904, 1'b1, 1'b1, 1'b0);
    service(0, 1, fr, rr);
  endtask

  task automatic test_hit_lru();
    int fr, rr;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 16'h0050; hit_i = 1'b1; hit_way_i = 1'b0;
    valid0_i = 1'b1; valid1_i = 1'b1;
    checks++; if (req_ready_o !== 1'b1) $display("FAIL hit_ready: got %b expected 1", req_ready_o); else passes++;
    lru_m[7'h05] = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0; hit_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({resp_valid_o, mem_req_o, req_ready_o} !== 3'b001)
      $display("FAIL hit_idle: got resp/mem_req/ready %b expected 001", {resp_valid_o, mem_req_o, req_ready_o});
    else passes++;
    start_miss(16'h8058, 1'b1, 1'b1, 1'b0);
    service(0, 1, fr, rr);
  endtask

  task automatic test_wait_states();
    int fr, rr;
    start_miss(16'h1234, 1'b1, 1'b1, 1'b0);
    service(3, 1, fr, rr);
    checks++; if (fr != 17) $display("FAIL wait_fill_latency: got %0d expected 17", fr); else passes++;
    checks++; if (rr != 18) $display("FAIL wait_resp_latency: got %0d expected 18", rr); else passes++;
  endtask

  task automatic test_reset_mid_refill();
    int   fr, rr;
    logic found;
    found = 1'b0;
    start_miss(16'h2468, 1'b0, 1'b0, 1'b0);
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_req_o) begin
        if (mem_addr_o === 16'h2468) begin
          rst_i       = 1'b1;
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_word(mem_addr_o);
          found       = 1'b1;
          break;
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = mem_word(mem_addr_o);
      end
    end
    checks++; if (found !== 1'b1) $display("FAIL beat2_timeout: got %b expected 1", found); else passes++;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_model();
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, mem_req_o, fill_we_o} !== 3'b100)
      $display("FAIL abort_idle: got ready/mem_req/fill_we %b expected 100", {req_ready_o, mem_req_o, fill_we_o});
    else passes++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if ({mem_req_o, fill_we_o, resp_valid_o} !== 3'b000)
        $display("FAIL stray_ack: got mem_req/fill_we/resp %b expected 000", {mem_req_o, fill_we_o, resp_valid_o});
      else passes++;
    end
    mem_ack_i = 1'b0;
    start_miss(16'h3104, 1'b1, 1'b1, 1'b0);
    service(0, 1, fr, rr);
  endtask

  task automatic test_back_to_back();
    int fr, rr;
    start_miss(16'h4560, 1'b0, 1'b0, 1'b1);
    req_addr_i = 16'h5574;
    service(0, 1, fr, rr);
    push_miss(16'h5574, 1'b0, 1'b0);
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1) $display("FAIL b2b_ready_after_resp: got %b expected 1", req_ready_o); else passes++;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    service(0, 1, fr, rr);
    checks++; if (fr != 5) $display("FAIL b2b_fill_latency: got %0d expected 5", fr); else passes++;
    checks++;
    if (exp_addr_q.size() + exp_fill_q.size() + exp_resp_q.size() != 0)
      $display("FAIL b2b_drain: got %0d pending expected 0", exp_addr_q.size() + exp_fill_q.size() + exp_resp_q.size());
    else passes++;
  endtask

  initial begin
    test_reset();
    test_miss_basic();
    test_victim_select();
    test_hit_lru();
    test_wait_states();
    test_reset_mid_refill();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
